alu_serial_ctrl: RTL and testbench

- Sequencer that runs WIDTH-bit operations through the team's 1-bit ALU slice, one bit per clock, LSB first.
- Carry ripples through an internal register between bits.
- Valid/ready command port in, valid/ready result port out.
- Sits between a register-file or bus front-end and the single-bit ALU cell, so wide arithmetic costs one slice instead of WIDTH slices.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 34 +++
 rtl/alu_serial_ctrl.sv | 106 ++++++++++
 tb/tb_alu_serial_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcodes and controller state encoding shared by the 1-bit ALU slice and the
// serial controller that sequences it.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Only ADD and SUB propagate a carry between bit positions.
    function automatic logic is_arith(input logic [2:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 1-bit ALU slice; SUB inverts b so the caller supplies the +1
// through cin on the least significant bit.
module alu
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] sel,
    output logic       y,
    output logic       cout
);

    logic bx;

    always_comb begin
        y    = 1'b0;
        cout = 1'b0;
        bx   = (sel == OP_SUB) ? ~b : b;
        case (sel)
            OP_ADD, OP_SUB: begin
                y    = a ^ bx ^ cin;
                cout = (a & bx) | (a & cin) | (bx & cin);
            end
            OP_MUL, OP_AND: y = a & b;
            OP_NOT:         y = ~a;
            OP_OR:          y = a | b;
            OP_XOR:         y = a ^ b;
            OP_XNOR:        y = ~(a ^ b);
            default:        y = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Runs WIDTH-bit operations through a single 1-bit ALU slice, LSB first, with
// valid/ready handshakes on the command and result sides.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [2:0]       op_q;
    logic             carry;
    logic             slice_y;
    logic             slice_cout;

    alu u_alu (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sel  (op_q),
        .y    (slice_y),
        .cout (slice_cout)
    );

    // DONE spends its first cycle publishing the finished shift register, so
    // result/zero/carry_out only ever reflect a fully completed operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            r_sh        <= '0;
            op_q        <= '0;
            carry       <= 1'b0;
            start_ready <= 1'b0;
            res_valid   <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            zero        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    start_ready <= 1'b1;
                    if (start_valid && start_ready) begin
                        a_sh        <= op_a;
                        b_sh        <= op_b;
                        r_sh        <= '0;
                        op_q        <= op_sel;
                        cnt         <= '0;
                        carry       <= (op_sel == OP_SUB);
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= {slice_y, r_sh[WIDTH-1:1]};
                    carry <= is_arith(op_q) ? slice_cout : 1'b0;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!res_valid) begin
                        result    <= r_sh;
                        zero      <= (r_sh == '0);
                        carry_out <= carry;
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed table, handshake corner
// cases, mid-operation reset and random operations against an arithmetic model.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [2:0]   op_sel;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_c;
        logic         exp_z;
    } vec_t;

    vec_t vecs[$];

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_sel      (op_sel),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Whole-word reference: plain integer arithmetic on the full operands.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] r, output logic c, output logic z);
        logic [W:0] s;
        s = '0;
        c = 1'b0;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b};            c = s[W]; end
            3'b001: begin s = {1'b0, a} + {1'b0, ~b} + 1'b1;    c = s[W]; end
            3'b010, 3'b100: s[W-1:0] = a & b;
            3'b011: s[W-1:0] = ~a;
            3'b101: s[W-1:0] = a | b;
            3'b110: s[W-1:0] = a ^ b;
            default: s[W-1:0] = ~(a ^ b);
        endcase
        r = s[W-1:0];
        z = (r == '0);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one command (called at a negedge), optionally spraying extra
    // start_valid pulses while busy, holds the result for 'hold' cycles, then
    // takes it and verifies the controller returns to idle without re-accepting.
    task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] a, b,
                                  input logic [W-1:0] exp_res, input logic exp_c, input logic exp_z,
                                  input int hold, input bit noise);
        int guard;
        int lat;
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_output("start_ready before cmd", start_ready, 1);
        op_a = a; op_b = b; op_sel = op; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = noise;
        op_a = W'($urandom); op_b = W'($urandom); op_sel = 3'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (res_valid) break;
            if (noise) begin
                op_a = W'($urandom); op_b = W'($urandom); op_sel = 3'($urandom);
            end
        end
        check_output("latency", lat, W + 1);
        check_output("result", result, exp_res);
        check_output("carry_out", carry_out, exp_c);
        check_output("zero", zero, exp_z);
        check_output("busy in DONE", busy, 1);
        check_output("start_ready in DONE", start_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output("held res_valid", res_valid, 1);
            check_output("held result", result, exp_res);
            check_output("held start_ready", start_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        check_output("res_valid after take", res_valid, 0);
        check_output("start_ready after take", start_ready, 1);
        check_output("busy after take", busy, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic [2:0]   rop;
        logic         ec, ez;
        int           guard;

        rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; op_sel = '0;

        vecs.push_back('{3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0});
        vecs.push_back('{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{3'b001, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0});
        vecs.push_back('{3'b001, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{3'b001, 8'h55, 8'h55, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{3'b010, 8'hC3, 8'hA5, 8'h81, 1'b0, 1'b0});
        vecs.push_back('{3'b011, 8'hC3, 8'hA5, 8'h3C, 1'b0, 1'b0});
        vecs.push_back('{3'b100, 8'hC3, 8'hA5, 8'h81, 1'b0, 1'b0});
        vecs.push_back('{3'b101, 8'hC3, 8'hA5, 8'hE7, 1'b0, 1'b0});
        vecs.push_back('{3'b110, 8'hC3, 8'hA5, 8'h66, 1'b0, 1'b0});
        vecs.push_back('{3'b111, 8'hC3, 8'hA5, 8'h99, 1'b0, 1'b0});

        #1;
        check_output("reset result", result, 0);
        check_output("reset res_valid", res_valid, 0);
        check_output("reset busy", busy, 0);
        check_output("reset start_ready", start_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle start_ready", start_ready, 1);
        check_output("idle busy", busy, 0);

        foreach (vecs[i])
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b,
                           vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_z, 0, 1'b0);

        // Backpressure with command spam during RUN and DONE.
        apply_stimulus(3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 5, 1'b1);

        // Abort three cycles into RUN.
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        op_a = 8'hFF; op_b = 8'h01; op_sel = 3'b000; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort result", result, 0);
        check_output("abort res_valid", res_valid, 0);
        check_output("abort busy", busy, 0);
        check_output("abort carry_out", carry_out, 0);
        check_output("abort zero", zero, 0);
        check_output("abort start_ready", start_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post-abort start_ready", start_ready, 1);
        apply_stimulus(3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0, 1'b0);

        // Random operations against the model, with random backpressure.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (i % 10 == 0) rb = ra;
            model(rop, ra, rb, er, ec, ez);
            apply_stimulus(rop, ra, rb, er, ec, ez, int'($urandom_range(0, 3)), i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
